// File: rtl/softmax_arb_pkg.sv
// Shared types for the two-client softmax_core arbiter: FSM states, client count and index type.
package softmax_arb_pkg;

    localparam int unsigned NUM_CLIENTS = 2;

    typedef logic [$clog2(NUM_CLIENTS)-1:0] client_idx_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn  = 2'd1,
        StRun  = 2'd2,
        StHold = 2'd3
    } arb_state_e;

    function automatic logic [NUM_CLIENTS-1:0] client_onehot(input client_idx_t c);
        logic [NUM_CLIENTS-1:0] oh;
        oh    = '0;
        oh[c] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/softmax_arb_port_mux.sv
// Combinational 2:1 mux of client BRAM port controls onto the core, forced quiet when nobody owns it.
module softmax_arb_port_mux
    import softmax_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 1028,
    parameter logic        EN_IDLE = 1'b0
) (
    input  logic                          valid_i,
    input  client_idx_t                   sel_i,
    input  logic [NUM_CLIENTS-1:0]        cena_i,
    input  logic [NUM_CLIENTS-1:0]        wea_i,
    input  logic [NUM_CLIENTS-1:0]        cenb_i,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] addra_i,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] addrb_i,
    input  logic [NUM_CLIENTS*DATA_W-1:0] dina_i,
    output logic                          core_cena_o,
    output logic                          core_wea_o,
    output logic                          core_cenb_o,
    output logic [ADDR_W-1:0]             core_addra_o,
    output logic [ADDR_W-1:0]             core_addrb_o,
    output logic [DATA_W-1:0]             core_dina_o
);

    always_comb begin
        core_cena_o  = EN_IDLE;
        core_cenb_o  = EN_IDLE;
        core_wea_o   = 1'b0;
        core_addra_o = '0;
        core_addrb_o = '0;
        core_dina_o  = '0;
        if (valid_i) begin
            core_cena_o  = cena_i[sel_i];
            core_wea_o   = wea_i[sel_i];
            core_cenb_o  = cenb_i[sel_i];
            core_addra_o = addra_i[int'(sel_i)*ADDR_W +: ADDR_W];
            core_addrb_o = addrb_i[int'(sel_i)*ADDR_W +: ADDR_W];
            core_dina_o  = dina_i[int'(sel_i)*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/softmax_core_arbiter.sv
// Lock-based round-robin arbiter time-sharing one softmax_core between two clients,
// with start validation and a busy-timeout watchdog.
module softmax_core_arbiter
    import softmax_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 1028,
    parameter int unsigned DEPTH_W = 8,
    parameter int unsigned TIMEOUT = 4096,
    parameter logic        EN_IDLE = 1'b0
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_CLIENTS-1:0]        i_req,
    output logic [NUM_CLIENTS-1:0]        o_gnt,
    input  logic [NUM_CLIENTS-1:0]        i_start,
    input  logic [NUM_CLIENTS*DEPTH_W-1:0] i_depth,
    output logic [NUM_CLIENTS-1:0]        o_done,
    output logic [NUM_CLIENTS-1:0]        o_err,
    input  logic [NUM_CLIENTS-1:0]        i_cena,
    input  logic [NUM_CLIENTS-1:0]        i_wea,
    input  logic [NUM_CLIENTS-1:0]        i_cenb,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] i_addra,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] i_addrb,
    input  logic [NUM_CLIENTS*DATA_W-1:0] i_dina,
    output logic [DATA_W-1:0]             o_doutb,
    output logic                          o_core_cena,
    output logic                          o_core_wea,
    output logic                          o_core_cenb,
    output logic [ADDR_W-1:0]             o_core_addra,
    output logic [ADDR_W-1:0]             o_core_addrb,
    output logic [DATA_W-1:0]             o_core_dina,
    input  logic [DATA_W-1:0]             i_core_doutb,
    output logic                          o_core_start,
    output logic [DEPTH_W-1:0]            o_core_depth,
    input  logic                          i_core_busy,
    output logic [1:0]                    o_state
);

    localparam int unsigned WdW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    arb_state_e               state_q, state_d;
    logic [NUM_CLIENTS-1:0]   gnt_q, gnt_d;
    client_idx_t              rr_q, rr_d;
    logic [NUM_CLIENTS-1:0]   done_q, done_d;
    logic [NUM_CLIENTS-1:0]   err_q, err_d;
    logic                     start_q, start_d;
    logic [DEPTH_W-1:0]       depth_q, depth_d;
    logic [WdW-1:0]           wd_q, wd_d;
    logic                     seen_q, seen_d;

    client_idx_t              owner;
    client_idx_t              pick;
    logic                     own_req;
    logic                     own_start;
    logic [DEPTH_W-1:0]       own_depth;

    // Grant is one-hot, so the upper bit alone names the owner.
    assign owner     = gnt_q[1];
    assign own_req   = i_req[owner];
    assign own_start = i_start[owner];
    assign own_depth = owner ? i_depth[2*DEPTH_W-1:DEPTH_W] : i_depth[DEPTH_W-1:0];
    assign pick      = i_req[rr_q] ? rr_q : ~rr_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        done_d  = '0;
        start_d = 1'b0;
        depth_d = depth_q;
        wd_d    = wd_q;
        seen_d  = seen_q;
        // Any start from a client that does not hold the grant is flagged.
        err_d   = i_start & ~gnt_q;

        unique case (state_q)
            StIdle: begin
                if (|i_req) begin
                    gnt_d   = client_onehot(pick);
                    state_d = StOwn;
                end
            end
            StOwn, StHold: begin
                if (!own_req) begin
                    gnt_d   = '0;
                    rr_d    = ~owner;
                    state_d = StIdle;
                end else if (own_start) begin
                    if (own_depth == '0) begin
                        err_d[owner] = 1'b1;
                    end else begin
                        start_d = 1'b1;
                        depth_d = own_depth;
                        wd_d    = '0;
                        seen_d  = 1'b0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (i_core_busy) begin
                    seen_d = 1'b1;
                end
                if (seen_q && !i_core_busy) begin
                    done_d[owner] = 1'b1;
                    state_d       = StHold;
                end else if (wd_q == WdW'(TIMEOUT - 1)) begin
                    err_d[owner] = 1'b1;
                    state_d      = StHold;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            rr_q    <= '0;
            done_q  <= '0;
            err_q   <= '0;
            start_q <= 1'b0;
            depth_q <= '0;
            wd_q    <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
            depth_q <= depth_d;
            wd_q    <= wd_d;
            seen_q  <= seen_d;
        end
    end

    softmax_arb_port_mux #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .EN_IDLE (EN_IDLE)
    ) u_port_mux (
        .valid_i      (|gnt_q),
        .sel_i        (owner),
        .cena_i       (i_cena),
        .wea_i        (i_wea),
        .cenb_i       (i_cenb),
        .addra_i      (i_addra),
        .addrb_i      (i_addrb),
        .dina_i       (i_dina),
        .core_cena_o  (o_core_cena),
        .core_wea_o   (o_core_wea),
        .core_cenb_o  (o_core_cenb),
        .core_addra_o (o_core_addra),
        .core_addrb_o (o_core_addrb),
        .core_dina_o  (o_core_dina)
    );

    assign o_gnt        = gnt_q;
    assign o_done       = done_q;
    assign o_err        = err_q;
    assign o_core_start = start_q;
    assign o_core_depth = depth_q;
    assign o_state      = state_q;
    assign o_doutb      = i_core_doutb;

endmodule

// File: tb/tb_softmax_core_arbiter.sv
// Directed bench for softmax_core_arbiter: a small BRAM model stands in for the core's memory.
module tb_softmax_core_arbiter;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned DEPTH_W = 8;
    localparam int unsigned TIMEOUT = 16;
    localparam logic        EN_IDLE = 1'b0;

    logic                  i_clk;
    logic                  i_rst;
    logic [1:0]            i_req;
    logic [1:0]            o_gnt;
    logic [1:0]            i_start;
    logic [2*DEPTH_W-1:0]  i_depth;
    logic [1:0]            o_done;
    logic [1:0]            o_err;
    logic [1:0]            i_cena;
    logic [1:0]            i_wea;
    logic [1:0]            i_cenb;
    logic [2*ADDR_W-1:0]   i_addra;
    logic [2*ADDR_W-1:0]   i_addrb;
    logic [2*DATA_W-1:0]   i_dina;
    logic [DATA_W-1:0]     o_doutb;
    logic                  o_core_cena;
    logic                  o_core_wea;
    logic                  o_core_cenb;
    logic [ADDR_W-1:0]     o_core_addra;
    logic [ADDR_W-1:0]     o_core_addrb;
    logic [DATA_W-1:0]     o_core_dina;
    logic [DATA_W-1:0]     i_core_doutb;
    logic                  o_core_start;
    logic [DEPTH_W-1:0]    o_core_depth;
    logic                  i_core_busy;
    logic [1:0]            o_state;

    int n_pass;
    int n_total;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    softmax_core_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH_W (DEPTH_W),
        .TIMEOUT (TIMEOUT),
        .EN_IDLE (EN_IDLE)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req        (i_req),
        .o_gnt        (o_gnt),
        .i_start      (i_start),
        .i_depth      (i_depth),
        .o_done       (o_done),
        .o_err        (o_err),
        .i_cena       (i_cena),
        .i_wea        (i_wea),
        .i_cenb       (i_cenb),
        .i_addra      (i_addra),
        .i_addrb      (i_addrb),
        .i_dina       (i_dina),
        .o_doutb      (o_doutb),
        .o_core_cena  (o_core_cena),
        .o_core_wea   (o_core_wea),
        .o_core_cenb  (o_core_cenb),
        .o_core_addra (o_core_addra),
        .o_core_addrb (o_core_addrb),
        .o_core_dina  (o_core_dina),
        .i_core_doutb (i_core_doutb),
        .o_core_start (o_core_start),
        .o_core_depth (o_core_depth),
        .i_core_busy  (i_core_busy),
        .o_state      (o_state)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Stand-in for the core's BRAM: port A writes, port B registered read.
    always @(posedge i_clk) begin
        if (o_core_cena && o_core_wea) mem[o_core_addra] <= o_core_dina;
        if (o_core_cenb) i_core_doutb <= mem[o_core_addrb];
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        n_total++;
        if (o_gnt !== 2'b00) $display("FAIL reset_gnt got=%b exp=00", o_gnt); else n_pass++;
        n_total++;
        if (o_state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", o_state); else n_pass++;
        n_total++;
        if (o_done !== 2'b00 || o_err !== 2'b00 || o_core_start !== 1'b0)
            $display("FAIL reset_pulses got done=%b err=%b start=%b exp=0", o_done, o_err, o_core_start);
        else n_pass++;
        n_total++;
        if (o_core_depth !== 8'd0 || o_core_cena !== EN_IDLE || o_core_cenb !== EN_IDLE)
            $display("FAIL reset_core got depth=%0d cena=%b cenb=%b exp=0", o_core_depth, o_core_cena,
                     o_core_cenb);
        else n_pass++;
    endtask

    task automatic test_single();
        logic [DATA_W-1:0] wdata;
        i_req = 2'b01;
        tick();
        n_total++;
        if (o_gnt !== 2'b01 || o_state !== 2'd1)
            $display("FAIL single_grant got gnt=%b state=%0d exp gnt=01 state=1", o_gnt, o_state);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            wdata = 64'hA5A5_0000_0000_0000 + DATA_W'(k * 17 + 3);
            i_cena[0] = 1'b1;
            i_wea[0]  = 1'b1;
            i_addra[ADDR_W-1:0] = ADDR_W'(k);
            i_dina[DATA_W-1:0]  = wdata;
            #1;
            n_total++;
            if (o_core_addra !== ADDR_W'(k) || o_core_dina !== wdata || o_core_wea !== 1'b1)
                $display("FAIL single_wr_mux got addr=%0d data=%h exp addr=%0d data=%h", o_core_addra,
                         o_core_dina, k, wdata);
            else n_pass++;
            tick();
        end
        i_cena = 2'b00;
        i_wea  = 2'b00;
        i_start = 2'b01;
        i_depth[DEPTH_W-1:0] = 8'd3;
        tick();
        i_start = 2'b00;
        n_total++;
        if (o_core_start !== 1'b1 || o_core_depth !== 8'd3 || o_state !== 2'd2)
            $display("FAIL single_start got start=%b depth=%0d state=%0d exp 1/3/2", o_core_start,
                     o_core_depth, o_state);
        else n_pass++;
        i_core_busy = 1'b1;
        tick();
        n_total++;
        if (o_core_start !== 1'b0) $display("FAIL single_start_len got=%b exp=0", o_core_start);
        else n_pass++;
        for (int i = 0; i < 9; i++) tick();
        i_core_busy = 1'b0;
        tick();
        n_total++;
        if (o_done !== 2'b01 || o_state !== 2'd3)
            $display("FAIL single_done got done=%b state=%0d exp 01/3", o_done, o_state);
        else n_pass++;
        tick();
        n_total++;
        if (o_done !== 2'b00) $display("FAIL single_done_len got=%b exp=00", o_done); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            wdata = 64'hA5A5_0000_0000_0000 + DATA_W'(k * 17 + 3);
            i_cenb[0] = 1'b1;
            i_addrb[ADDR_W-1:0] = ADDR_W'(k);
            tick();
            n_total++;
            if (o_doutb !== wdata)
                $display("FAIL single_readback addr=%0d got=%h exp=%h", k, o_doutb, wdata);
            else n_pass++;
        end
        i_cenb = 2'b00;
        i_req  = 2'b00;
        tick();
        n_total++;
        if (o_gnt !== 2'b00 || o_state !== 2'd0)
            $display("FAIL single_release got gnt=%b state=%0d exp 00/0", o_gnt, o_state);
        else n_pass++;
    endtask

    task automatic test_contention();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_req = 2'b11;
        tick();
        n_total++;
        if (o_gnt !== 2'b01) $display("FAIL cont_first got=%b exp=01", o_gnt); else n_pass++;
        i_req = 2'b10;
        tick();
        n_total++;
        if (o_gnt !== 2'b00 || o_state !== 2'd0)
            $display("FAIL cont_idle_gap got gnt=%b state=%0d exp 00/0", o_gnt, o_state);
        else n_pass++;
        tick();
        n_total++;
        if (o_gnt !== 2'b10) $display("FAIL cont_second got=%b exp=10", o_gnt); else n_pass++;
        i_req = 2'b11;
        for (int i = 0; i < 4; i++) tick();
        n_total++;
        if (o_gnt !== 2'b10) $display("FAIL cont_wait got=%b exp=10", o_gnt); else n_pass++;
        i_req = 2'b01;
        tick();
        tick();
        n_total++;
        if (o_gnt !== 2'b01) $display("FAIL cont_handback got=%b exp=01", o_gnt); else n_pass++;
        i_req = 2'b00;
        tick();
    endtask

    task automatic test_illegal();
        i_req = 2'b01;
        tick();
        i_cena = 2'b10;
        #1;
        n_total++;
        if (o_core_cena !== 1'b0) $display("FAIL illegal_nonowner_bram got=%b exp=0", o_core_cena);
        else n_pass++;
        i_cena  = 2'b00;
        i_start = 2'b10;
        i_depth[2*DEPTH_W-1:DEPTH_W] = 8'd5;
        tick();
        i_start = 2'b00;
        n_total++;
        if (o_err !== 2'b10 || o_core_start !== 1'b0 || o_state !== 2'd1)
            $display("FAIL illegal_nonowner_start got err=%b start=%b state=%0d exp 10/0/1", o_err,
                     o_core_start, o_state);
        else n_pass++;
        i_start = 2'b01;
        i_depth[DEPTH_W-1:0] = 8'd0;
        tick();
        i_start = 2'b00;
        n_total++;
        if (o_err !== 2'b01 || o_core_start !== 1'b0 || o_state !== 2'd1)
            $display("FAIL illegal_depth0 got err=%b start=%b state=%0d exp 01/0/1", o_err,
                     o_core_start, o_state);
        else n_pass++;
        tick();
        n_total++;
        if (o_err !== 2'b00) $display("FAIL illegal_err_len got=%b exp=00", o_err); else n_pass++;
    endtask

    task automatic test_watchdog();
        int early;
        early = 0;
        i_start = 2'b01;
        i_depth[DEPTH_W-1:0] = 8'd4;
        tick();
        i_start = 2'b00;
        i_core_busy = 1'b1;
        n_total++;
        if (o_core_start !== 1'b1) $display("FAIL wd_start got=%b exp=1", o_core_start); else n_pass++;
        for (int i = 1; i < 16; i++) begin
            tick();
            if (o_err !== 2'b00 || o_state !== 2'd2) early++;
        end
        n_total++;
        if (early != 0) $display("FAIL wd_early got=%0d cycles exp=0", early); else n_pass++;
        tick();
        n_total++;
        if (o_err !== 2'b01 || o_state !== 2'd3 || o_done !== 2'b00)
            $display("FAIL wd_fire got err=%b state=%0d done=%b exp 01/3/00", o_err, o_state, o_done);
        else n_pass++;
        i_req = 2'b00;
        tick();
        n_total++;
        if (o_gnt !== 2'b00 || o_state !== 2'd0)
            $display("FAIL wd_release got gnt=%b state=%0d exp 00/0", o_gnt, o_state);
        else n_pass++;
        i_core_busy = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_run();
        i_req = 2'b01;
        tick();
        i_start = 2'b01;
        i_depth[DEPTH_W-1:0] = 8'd2;
        tick();
        i_start = 2'b00;
        i_core_busy = 1'b1;
        i_req = 2'b00;
        tick();
        n_total++;
        if (o_gnt !== 2'b01 || o_state !== 2'd2)
            $display("FAIL run_req_drop got gnt=%b state=%0d exp 01/2", o_gnt, o_state);
        else n_pass++;
        i_cena = 2'b01;
        i_rst  = 1'b1;
        tick();
        n_total++;
        if (o_gnt !== 2'b00 || o_core_start !== 1'b0 || o_state !== 2'd0 || o_core_cena !== EN_IDLE)
            $display("FAIL rst_mid_run got gnt=%b start=%b state=%0d cena=%b exp 00/0/0/0", o_gnt,
                     o_core_start, o_state, o_core_cena);
        else n_pass++;
        i_rst = 1'b0;
        i_cena = 2'b00;
        i_core_busy = 1'b0;
        tick();
    endtask

    task automatic test_client1_run();
        i_req = 2'b10;
        tick();
        n_total++;
        if (o_gnt !== 2'b10) $display("FAIL c1_grant got=%b exp=10", o_gnt); else n_pass++;
        i_cena = 2'b10;
        i_addra = {8'h5A, 8'h33};
        #1;
        n_total++;
        if (o_core_addra !== 8'h5A || o_core_cena !== 1'b1)
            $display("FAIL c1_mux got addr=%h cena=%b exp 5a/1", o_core_addra, o_core_cena);
        else n_pass++;
        i_cena = 2'b00;
        i_start = 2'b10;
        i_depth = {8'd7, 8'd0};
        tick();
        i_start = 2'b00;
        n_total++;
        if (o_core_start !== 1'b1 || o_core_depth !== 8'd7)
            $display("FAIL c1_start got start=%b depth=%0d exp 1/7", o_core_start, o_core_depth);
        else n_pass++;
        i_core_busy = 1'b1;
        tick();
        tick();
        i_core_busy = 1'b0;
        tick();
        n_total++;
        if (o_done !== 2'b10) $display("FAIL c1_done got=%b exp=10", o_done); else n_pass++;
        i_req = 2'b00;
        tick();
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        i_rst = 1'b1;
        i_req = '0;
        i_start = '0;
        i_depth = '0;
        i_cena = '0;
        i_wea = '0;
        i_cenb = '0;
        i_addra = '0;
        i_addrb = '0;
        i_dina = '0;
        i_core_busy = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_illegal();
        test_watchdog();
        test_reset_mid_run();
        test_client1_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/softmax_core_arbiter.md
Name: softmax_core_arbiter

Overview:
Two-client arbiter that time-shares one softmax_core, including its external BRAM ports A/B and its start/depth/busy control. Client 0 is the UART/BRAM host controller; client 1 is a second on-chip requester, such as a self-test pattern generator. Ownership is round-robin and lock-based: a granted client loads, starts, collects results and releases before the other client is served. The block also adds start validation and a busy-timeout watchdog.

Parameters:
ADDR_W, 8, BRAM address width
DATA_W, 1028, BRAM word width
DEPTH_W, 8, core depth width
TIMEOUT, 4096, max cycles in RUN before forced abort
EN_IDLE, 1'b0, level driven on core cena/cenb when no client owns the core

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_req  in  2  per-client ownership request, level
o_gnt  out  2  one-hot grant, registered
i_start  in  2  per-client start pulse, honoured only for owner
i_depth  in  2*DEPTH_W  per-client depth, packed {c1,c0}
o_done  out  2  one-cycle done pulse to owner
o_err  out  2  one-cycle error pulse to offending client
i_cena/i_wea/i_cenb  in  2 each  per-client BRAM controls
i_addra/i_addrb  in  2*ADDR_W  per-client addresses
i_dina  in  2*DATA_W  per-client write data
o_doutb  out  DATA_W  core read data, broadcast to both clients
o_core_cena/o_core_wea/o_core_cenb  out  1  to core
o_core_addra/o_core_addrb  out  ADDR_W  to core
o_core_dina  out  DATA_W  to core
i_core_doutb  in  DATA_W  from core
o_core_start  out  1  registered start pulse
o_core_depth  out  DEPTH_W  latched depth
i_core_busy  in  1  core busy
o_state  out  2  debug, state encoding

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst is synchronous and active-high.
- Reset values: o_gnt=0, o_done=0, o_err=0, o_core_start=0, o_core_depth=0, state=IDLE, rr pointer=client 0.
- Reset mid-operation drops the grant immediately. The core shares i_rst, so no drain is needed.
- FSM states: IDLE(0), OWN(1), RUN(2), HOLD(3).
- IDLE:
  - If any i_req is set, grant the client selected by the rr pointer when it requests, otherwise the other client.
  - o_gnt is asserted the cycle after req is sampled: 1-cycle latency.
  - Go to OWN.
- OWN:
  - The owner's BRAM signals pass combinationally to the core ports; the owner is decoded from the registered o_gnt.
  - Owner i_start with depth != 0: next cycle o_core_start=1 for exactly 1 cycle, o_core_depth latched; go to RUN.
  - Owner i_start with depth==0: o_err pulse to owner, no core start, stay in OWN.
  - Owner i_req low: release. o_gnt=0 next cycle, rr pointer moves to the other client, go to IDLE.
  - In IDLE, at least one cycle elapses before any new grant.
- RUN:
  - Owner BRAM ports stay muxed.
  - Wait for i_core_busy to rise, then fall.
  - On the falling edge: o_done pulse to owner, go to HOLD.
  - Watchdog counter runs from the start cycle. At TIMEOUT-1 without the busy fall: o_err pulse to owner, go to HOLD.
  - i_start during RUN is ignored. A req drop during RUN is deferred until the core is no longer busy.
- HOLD:
  - Owner reads results.
  - A new valid start returns to RUN, same rules as in OWN.
  - i_req low releases, same as from OWN.
- Non-owner client:
  - Its i_start raises o_err for that client for 1 cycle; no other effect.
  - Its BRAM controls are ignored.
- No owner (IDLE):
  - core cena/cenb = EN_IDLE, wea=0, addresses/data=0.
- o_doutb = i_core_doutb, unregistered.
- Simultaneous requests are resolved by the rr pointer. With back-to-back requests, each client gets the core in turn, so there is no starvation.

Decomposition:
- Package softmax_arb_pkg holds:
  - state enum: IDLE, OWN, RUN, HOLD
  - client count constant NUM_CLIENTS=2
  - client index typedef
- One sub-module, softmax_arb_port_mux: the combinational 2:1 BRAM port mux with idle forcing.
- FSM, rr pointer and watchdog live in the top.

Test Plan:
- Single client: c0 req, write 3 words at addr 0..2, start with depth=3 → o_core_start 1-cycle pulse with o_core_depth=3; busy held 10 cycles then falls → o_done[0] pulse the cycle after the fall; readback of addr 0..2 matches core data.
- Contention: both req asserted in the same cycle after reset → o_gnt=2'b01. c0 releases → ≥1 IDLE cycle, then o_gnt=2'b10. c0 re-requests while c1 owns → c0 waits until c1 releases.
- Illegal starts: c1 pulses start while c0 owns → o_err=2'b10, no o_core_start. c0 starts with depth=0 → o_err=2'b01, state stays OWN.
- Watchdog: TIMEOUT=16, busy held high forever after start → o_err[owner] at cycle 16, state=HOLD, release then works.
- Reset mid-RUN: assert i_rst during RUN → next cycle o_gnt=0, o_core_start=0, state=IDLE, core cena=EN_IDLE.
